// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NR_REQ requesters using round-robin arbitration.
// ALU results are captured in a 2-entry FIFO, tagged with the requester index and trans_id.
package alu_share_pkg;
  localparam int TRANS_ID_BITS = 3;

  // ADD has to stay at encoding 0 so that an all-zero fu_data_t is a legal idle ALU input.
  typedef enum logic [3:0] {
    ADD, SUB, XORL, ORL, ANDL, EQ, NE, LTS, LTU, GES, GEU
  } fu_op_e;

  typedef struct packed {
    fu_op_e                   operation;
    logic [63:0]              operand_a;
    logic [63:0]              operand_b;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;
endpackage

module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NR_REQ = 2,
  parameter int IDX_W  = $clog2(NR_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [NR_REQ-1:0]        req_valid_i,
  output logic [NR_REQ-1:0]        req_ready_o,
  input  fu_data_t                 req_data_i [NR_REQ],
  output fu_data_t                 alu_fu_data_o,
  input  logic [63:0]              alu_result_i,
  input  logic                     alu_branch_res_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [63:0]              res_result_o,
  output logic                     res_branch_o,
  output logic [IDX_W-1:0]         res_idx_o,
  output logic [TRANS_ID_BITS-1:0] res_trans_id_o
);

  typedef struct packed {
    logic [63:0]              result;
    logic                     branch;
    logic [IDX_W-1:0]         idx;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } entry_t;

  logic [IDX_W-1:0] r_rr;
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_cnt;
  entry_t           r_mem [2];

  logic             w_any;
  logic [IDX_W-1:0] w_gnt_idx;
  logic             w_can_accept;
  logic             w_push;
  logic             w_pop;

  always_comb begin : arbitrate
    int idx;
    // NOTE: every variable gets a default before the loop, so no path can infer a latch.
    w_any     = 1'b0;
    w_gnt_idx = '0;
    idx       = 0;
    for (int k = 0; k < NR_REQ; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= NR_REQ) idx = idx - NR_REQ;
      if (!w_any && req_valid_i[IDX_W'(idx)]) begin
        w_any     = 1'b1;
        w_gnt_idx = IDX_W'(idx);
      end
    end
  end

  assign res_valid_o  = (r_cnt != 2'd0);
  assign w_can_accept = (r_cnt < 2'd2) || (res_valid_o && res_ready_i);
  // The rst_ni term keeps req_ready_o low while reset is held.
  assign w_push       = w_any && w_can_accept && !flush_i && rst_ni;
  assign w_pop        = res_valid_o && res_ready_i && !flush_i;

  always_comb begin
    req_ready_o            = '0;
    req_ready_o[w_gnt_idx] = w_push;
  end

  assign alu_fu_data_o = w_any ? req_data_i[w_gnt_idx] : fu_data_t'('0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr     <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
      // NOTE: entry storage is reset so that the head data reads zero during reset and after it.
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (flush_i) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      // NOTE: state uses <=, so every register below updates from pre-edge values.
      if (w_push) begin
        r_mem[r_wptr] <= '{result:   alu_result_i,
                           branch:   alu_branch_res_i,
                           idx:      w_gnt_idx,
                           trans_id: alu_fu_data_o.trans_id};
        r_wptr        <= ~r_wptr;
        r_rr          <= (w_gnt_idx == IDX_W'(NR_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 2'd1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 2'd1;
    end
  end

  assign res_result_o   = r_mem[r_rptr].result;
  assign res_branch_o   = r_mem[r_rptr].branch;
  assign res_idx_o      = r_mem[r_rptr].idx;
  assign res_trans_id_o = r_mem[r_rptr].trans_id;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: table vectors, directed corner sequences
// and a randomized run against a queue-based reference model (NR_REQ = 2 and 3).
module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_ni;
  logic flush;

  // NR_REQ = 2 instance
  logic [1:0]               v2, rdy2;
  fu_data_t                 d2 [2];
  fu_data_t                 a2;
  logic [63:0]              ar2, res2;
  logic                     ab2, rv2, rr2i, br2;
  logic [0:0]               idx2;
  logic [TRANS_ID_BITS-1:0] tid2;

  // NR_REQ = 3 instance
  logic [2:0]               v3, rdy3;
  fu_data_t                 d3 [3];
  fu_data_t                 a3;
  logic [63:0]              ar3, res3;
  logic                     ab3, rv3, rr3i, br3;
  logic [1:0]               idx3;
  logic [TRANS_ID_BITS-1:0] tid3;

  int n_checks = 0;
  int n_fail   = 0;

  alu_share_arbiter #(.NR_REQ(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
    .req_valid_i(v2), .req_ready_o(rdy2), .req_data_i(d2),
    .alu_fu_data_o(a2), .alu_result_i(ar2), .alu_branch_res_i(ab2),
    .res_valid_o(rv2), .res_ready_i(rr2i), .res_result_o(res2),
    .res_branch_o(br2), .res_idx_o(idx2), .res_trans_id_o(tid2)
  );

  alu_share_arbiter #(.NR_REQ(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(1'b0),
    .req_valid_i(v3), .req_ready_o(rdy3), .req_data_i(d3),
    .alu_fu_data_o(a3), .alu_result_i(ar3), .alu_branch_res_i(ab3),
    .res_valid_o(rv3), .res_ready_i(rr3i), .res_result_o(res3),
    .res_branch_o(br3), .res_idx_o(idx3), .res_trans_id_o(tid3)
  );

  // Behavioural ALU: returns {branch, result}.
  function automatic logic [64:0] alu_fn(input fu_data_t d);
    logic [63:0] r;
    logic        b;
    r = '0;
    b = 1'b0;
    case (d.operation)
      ADD:  r = d.operand_a + d.operand_b;
      SUB:  r = d.operand_a - d.operand_b;
      XORL: r = d.operand_a ^ d.operand_b;
      ORL:  r = d.operand_a | d.operand_b;
      ANDL: r = d.operand_a & d.operand_b;
      EQ:   b = (d.operand_a == d.operand_b);
      NE:   b = (d.operand_a != d.operand_b);
      LTS:  b = ($signed(d.operand_a) < $signed(d.operand_b));
      LTU:  b = (d.operand_a < d.operand_b);
      GES:  b = ($signed(d.operand_a) >= $signed(d.operand_b));
      GEU:  b = (d.operand_a >= d.operand_b);
      default: ;
    endcase
    return {b, r};
  endfunction

  always_comb {ab2, ar2} = alu_fn(a2);
  always_comb {ab3, ar3} = alu_fn(a3);

  function automatic fu_data_t mk(input fu_op_e op, input logic [63:0] a, input logic [63:0] b,
                                  input logic [TRANS_ID_BITS-1:0] tid);
    fu_data_t d;
    d.operation = op;
    d.operand_a = a;
    d.operand_b = b;
    d.trans_id  = tid;
    return d;
  endfunction

  function automatic fu_data_t rand_req();
    fu_op_e ops [8] = '{ADD, SUB, XORL, ANDL, EQ, NE, LTS, LTU};
    logic [63:0] a, b;
    if ($urandom_range(1) == 0) begin
      a = 64'($urandom_range(15));
      b = 64'($urandom_range(15));
    end else begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
    end
    return mk(ops[$urandom_range(7)], a, b, TRANS_ID_BITS'($urandom_range(7)));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    v2 = '0; v3 = '0; flush = 1'b0; rr2i = 1'b0; rr3i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  typedef struct {
    int                       req;
    fu_op_e                   op;
    logic [63:0]              a;
    logic [63:0]              b;
    logic [TRANS_ID_BITS-1:0] tid;
    logic [1:0]               exp_rdy;
    logic [63:0]              exp_res;
    logic                     exp_br;
  } vec_t;

  typedef struct {
    logic [63:0]              res;
    logic                     br;
    int                       idx;
    logic [TRANS_ID_BITS-1:0] tid;
  } mentry_t;

  initial begin
    vec_t     vecs [8];
    mentry_t  q [$];
    bit       pend [2];
    int       rr_m, g;
    bit       any, acc;
    fu_data_t ef;
    logic [64:0] ab;

    vecs[0] = '{0, ADD,  64'd5,  64'd7, 3'd3, 2'b01, 64'd12, 1'b0};
    vecs[1] = '{1, SUB,  64'd10, 64'd3, 3'd5, 2'b10, 64'd7,  1'b0};
    vecs[2] = '{0, NE,   64'd4,  64'd4, 3'd1, 2'b01, 64'd0,  1'b0};
    vecs[3] = '{1, EQ,   64'd9,  64'd9, 3'd2, 2'b10, 64'd0,  1'b1};
    vecs[4] = '{0, LTS,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd6, 2'b01, 64'd0, 1'b1};
    vecs[5] = '{1, LTU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd7, 2'b10, 64'd0, 1'b0};
    vecs[6] = '{0, XORL, 64'hF0, 64'hFF, 3'd0, 2'b01, 64'h0F, 1'b0};
    vecs[7] = '{1, ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd4, 2'b10, 64'd0, 1'b0};

    // Reset state, with requests already asserted while reset is held
    rst_ni = 1'b0; flush = 1'b0; rr2i = 1'b0; rr3i = 1'b0; v3 = '0;
    v2 = 2'b11;
    d2[0] = mk(ADD, 64'd1, 64'd2, 3'd1);
    d2[1] = mk(SUB, 64'd5, 64'd2, 3'd2);
    for (int i = 0; i < 3; i++) d3[i] = fu_data_t'('0);
    @(negedge clk); #1;
    check("rst_ready",  64'(rdy2), 64'd0);
    check("rst_valid",  64'(rv2),  64'd0);
    check("rst_result", res2,      64'd0);
    check("rst_branch", 64'(br2),  64'd0);
    check("rst_idx",    64'(idx2), 64'd0);
    check("rst_tid",    64'(tid2), 64'd0);
    check("rst_alu_a",  a2.operand_a, 64'd1);
    v2 = '0;
    @(negedge clk);
    rst_ni = 1'b1;

    // Table vectors: one request at a time, consumer always ready
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rr2i = 1'b1;
      v2 = 2'(1 << vecs[i].req);
      d2[vecs[i].req] = mk(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tid);
      #1;
      check("vec_ready", 64'(rdy2), 64'(vecs[i].exp_rdy));
      check("vec_alu_a", a2.operand_a, vecs[i].a);
      @(negedge clk);
      v2 = '0;
      #1;
      check("vec_valid",  64'(rv2),  64'd1);
      check("vec_result", res2,      vecs[i].exp_res);
      check("vec_branch", 64'(br2),  64'(vecs[i].exp_br));
      check("vec_idx",    64'(idx2), 64'(vecs[i].req));
      check("vec_tid",    64'(tid2), 64'(vecs[i].tid));
      check("idle_alu_zero", 64'(a2 != fu_data_t'('0)), 64'd0);
    end

    // Fairness: both requesters valid for 6 cycles
    do_reset();
    d2[0] = mk(ADD, 64'd1, 64'd1, 3'd0);
    d2[1] = mk(ADD, 64'd2, 64'd2, 3'd1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      rr2i = 1'b1;
      v2 = (k < 6) ? 2'b11 : 2'b00;
      #1;
      if (k < 6) check("fair_grant", 64'(rdy2), 64'(1 << (k % 2)));
      if (k > 0) begin
        check("fair_valid", 64'(rv2),  64'd1);
        check("fair_idx",   64'(idx2), 64'((k - 1) % 2));
      end
    end

    // Backpressure: fill both entries, third request waits, accepted on first pop
    do_reset();
    @(negedge clk);
    v2 = 2'b10; d2[1] = mk(SUB, 64'd10, 64'd3, 3'd1); #1;
    check("bp_acc1", 64'(rdy2), 64'b10);
    @(negedge clk);
    d2[1] = mk(NE, 64'd4, 64'd4, 3'd2); #1;
    check("bp_acc2", 64'(rdy2), 64'b10);
    check("bp_head1", res2, 64'd7);
    @(negedge clk);
    d2[1] = mk(ADD, 64'd1, 64'd1, 3'd3); #1;
    check("bp_full_ready", 64'(rdy2), 64'b00);
    check("bp_full_alu",   a2.operand_a, 64'd1);
    @(negedge clk);
    rr2i = 1'b1; #1;
    check("bp_acc3_on_pop", 64'(rdy2), 64'b10);
    check("bp_pop1_res", res2, 64'd7);
    check("bp_pop1_tid", 64'(tid2), 64'd1);
    @(negedge clk);
    v2 = '0; #1;
    check("bp_pop2_res", res2, 64'd0);
    check("bp_pop2_br",  64'(br2), 64'd0);
    check("bp_pop2_tid", 64'(tid2), 64'd2);
    @(negedge clk); #1;
    check("bp_pop3_res", res2, 64'd2);
    check("bp_pop3_tid", 64'(tid2), 64'd3);
    @(negedge clk); #1;
    check("bp_empty", 64'(rv2), 64'd0);

    // Flush with two entries queued; the round-robin pointer must survive the flush
    do_reset();
    @(negedge clk);
    v2 = 2'b01; d2[0] = mk(ADD, 64'd5, 64'd7, 3'd3); #1;
    check("fl_acc1", 64'(rdy2), 64'b01);
    @(negedge clk);
    d2[0] = mk(ADD, 64'd1, 64'd2, 3'd4); #1;
    check("fl_acc2", 64'(rdy2), 64'b01);
    @(negedge clk);
    v2 = 2'b11; d2[1] = mk(SUB, 64'd9, 64'd1, 3'd5); flush = 1'b1; rr2i = 1'b1; #1;
    check("fl_no_accept", 64'(rdy2), 64'b00);
    check("fl_valid_before", 64'(rv2), 64'd1);
    @(negedge clk);
    flush = 1'b0; rr2i = 1'b0; #1;
    check("fl_valid_after", 64'(rv2), 64'd0);
    check("fl_rr_held", 64'(rdy2), 64'b10);
    @(negedge clk);
    v2 = 2'b01; #1;
    check("fl_cnt_restart", 64'(rv2), 64'd1);
    check("fl_head_idx", 64'(idx2), 64'd1);
    check("fl_head_res", res2, 64'd8);
    check("fl_second_acc", 64'(rdy2), 64'b01);

    // Asynchronous reset between clock edges while the FIFO holds data
    do_reset();
    @(negedge clk);
    v2 = 2'b10; d2[1] = mk(SUB, 64'd10, 64'd3, 3'd5); #1;
    check("ar_acc1", 64'(rdy2), 64'b10);
    @(negedge clk);
    v2 = 2'b01; d2[0] = mk(ADD, 64'd5, 64'd7, 3'd3); #1;
    check("ar_acc2", 64'(rdy2), 64'b01);
    @(negedge clk);
    v2 = 2'b00; #1;
    check("ar_pre_res", res2, 64'd7);
    #1;
    rst_ni = 1'b0;
    #1;
    check("ar_valid", 64'(rv2),  64'd0);
    check("ar_res",   res2,      64'd0);
    check("ar_br",    64'(br2),  64'd0);
    check("ar_idx",   64'(idx2), 64'd0);
    check("ar_tid",   64'(tid2), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    v2 = 2'b11; rr2i = 1'b1; #1;
    check("ar_rr_zero", 64'(rdy2), 64'b01);
    check("ar_empty",   64'(rv2),  64'd0);

    // Wrap with NR_REQ = 3
    do_reset();
    @(negedge clk);
    rr3i = 1'b1; v3 = 3'b100; d3[2] = mk(ADD, 64'd2, 64'd0, 3'd2); #1;
    check("w3_first", 64'(rdy3), 64'b100);
    @(negedge clk);
    v3 = 3'b111;
    d3[0] = mk(ADD, 64'd10, 64'd0, 3'd0);
    d3[1] = mk(ADD, 64'd11, 64'd0, 3'd1);
    d3[2] = mk(ADD, 64'd12, 64'd0, 3'd2);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) v3 = 3'b000;
      #1;
      if (k < 3) check("w3_grant", 64'(rdy3), 64'(1 << k));
      check("w3_idx", 64'(idx3), 64'((k + 2) % 3));
      check("w3_res", res3, (k == 0) ? 64'd2 : 64'(9 + k));
      @(negedge clk);
    end
    #1;
    check("w3_empty", 64'(rv3), 64'd0);
    v3 = '0;

    // Randomized run against the queue model
    do_reset();
    rr_m = 0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(2) != 0) begin
          pend[i] = 1'b1;
          d2[i] = rand_req();
        end
      end
      v2 = {pend[1], pend[0]};
      rr2i = ($urandom_range(3) != 0);
      flush = ($urandom_range(15) == 0);
      #1;
      check("rnd_valid", 64'(rv2), 64'(q.size() != 0));
      if (q.size() != 0) begin
        check("rnd_res", res2,      q[0].res);
        check("rnd_br",  64'(br2),  64'(q[0].br));
        check("rnd_idx", 64'(idx2), 64'(q[0].idx));
        check("rnd_tid", 64'(tid2), 64'(q[0].tid));
      end
      any = 1'b0;
      g = 0;
      for (int k = 0; k < 2; k++) begin
        if (!any && pend[(rr_m + k) % 2]) begin
          any = 1'b1;
          g = (rr_m + k) % 2;
        end
      end
      acc = any && !flush && (q.size() < 2 || rr2i);
      ef = any ? d2[g] : fu_data_t'('0);
      check("rnd_ready", 64'(rdy2), acc ? 64'(1 << g) : 64'd0);
      check("rnd_alu_op",  64'(a2.operation), 64'(ef.operation));
      check("rnd_alu_a",   a2.operand_a, ef.operand_a);
      check("rnd_alu_b",   a2.operand_b, ef.operand_b);
      check("rnd_alu_tid", 64'(a2.trans_id), 64'(ef.trans_id));
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && rr2i) void'(q.pop_front());
        if (acc) begin
          ab = alu_fn(d2[g]);
          q.push_back('{ab[63:0], ab[64], g, d2[g].trans_id});
          rr_m = (g + 1) % 2;
          pend[g] = 1'b0;
        end
      end
    end
    flush = 1'b0;
    v2 = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter that shares one combinational `alu` instance between `NR_REQ` requesters, e.g. the integer issue port and the branch-resolve port. It muxes the granted requester's `fu_data_t` onto the ALU and captures `result_o`/`alu_branch_res_o` into a 2-entry result FIFO. Each FIFO entry is tagged with the requester index and `trans_id`. The block sits between issue and the ALU wrapper in the execute stage.

## Interface
- `NR_REQ`, default 2: number of requesters; legal range 2..8.
- `IDX_W`, default `$clog2(NR_REQ)`: requester index width.
- `clk_i` in 1: clock. All state is updated on the rising edge.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `flush_i` in 1: synchronous flush of the result FIFO.
- `req_valid_i` in `NR_REQ`: per-requester request valid.
- `req_ready_o` out `NR_REQ`: per-requester accept; at most one bit is set per cycle.
- `req_data_i` in `NR_REQ` x `fu_data_t`: per-requester operator, operands and `trans_id`.
- `alu_fu_data_o` out `fu_data_t`: data driven to the shared ALU.
- `alu_result_i` in 64: ALU `result_o`, combinational from `alu_fu_data_o`.
- `alu_branch_res_i` in 1: ALU `alu_branch_res_o`.
- `res_valid_o` out 1: the FIFO head is valid.
- `res_ready_i` in 1: consumer pops the head.
- `res_result_o` out 64: result at the FIFO head.
- `res_branch_o` out 1: branch result at the FIFO head.
- `res_idx_o` out `IDX_W`: index of the requester that produced the head entry.
- `res_trans_id_o` out `TRANS_ID_BITS`: `trans_id` of the head entry.

## Operation
- State:
  - round-robin pointer `rr_q` (`IDX_W` bits, reset 0);
  - 2-entry FIFO with write pointer `wptr_q`, read pointer `rptr_q` and count `cnt_q` (0..2);
  - entry storage.
- Accept condition: `can_accept = (cnt_q < 2) || (res_valid_o && res_ready_i)`.
- Arbitration:
  - Scan the requesters starting at `rr_q`, wrapping modulo `NR_REQ`.
  - The first requester with `req_valid_i` set wins, giving `gnt_idx`.
  - `req_ready_o[gnt_idx] = can_accept`; all other bits are 0.
  - If no request is valid, `req_ready_o` is all zeros.
- ALU drive:
  - `alu_fu_data_o = req_data_i[gnt_idx]` when any request is valid.
  - Otherwise `alu_fu_data_o` is all zeros; the operator field is then ADD, so all-zero is a legal ALU input.
- On an accept (a valid request and `can_accept`):
  - write `{alu_result_i, alu_branch_res_i, gnt_idx, trans_id}` to entry `wptr_q`;
  - advance `wptr_q`;
  - set `rr_q <= (gnt_idx + 1) mod NR_REQ`. When `NR_REQ` is not a power of 2, the wrap is explicit: `gnt_idx == NR_REQ-1` gives 0.
- Without an accept, `rr_q` holds.
- Pop: on `res_valid_o && res_ready_i`, advance `rptr_q`.
- Count update:
  - push and pop in the same cycle: `cnt_q` is unchanged;
  - push only: `cnt_q + 1`;
  - pop only: `cnt_q - 1`.
- Outputs: `res_valid_o = (cnt_q != 0)`. The `res_*` data outputs come from entry `rptr_q` and are registered, never combinational from `req_*`.
- `flush_i`:
  - sets `cnt_q`, `wptr_q` and `rptr_q` to 0;
  - forces `req_ready_o` to 0 in that cycle, so no accept and no pop;
  - leaves `rr_q` unchanged.
- Full FIFO (`cnt_q == 2`) with `res_ready_i == 0`: `req_ready_o` is all zeros and the ALU input keeps following the highest-priority valid request. The result is simply not captured.

## Timing
- Latency: a request accepted in cycle N appears at the FIFO head in cycle N+1 with `res_valid_o = 1`, provided the FIFO was empty.
- Throughput: 1 accept per cycle while the consumer keeps `res_ready_i` high. The FIFO absorbs one cycle of backpressure without losing throughput.
- Handshakes:
  - Requester side: a transfer occurs only when `req_valid_i[i] && req_ready_o[i]`.
  - Requesters hold valid and data stable until accepted.
  - `req_ready_o` depends combinationally on `req_valid_i`, `res_ready_i`, `cnt_q` and `flush_i`.
- Reset (asynchronous assertion, synchronous deassertion by the system):
  - `rr_q = 0`, `cnt_q = 0`, both pointers 0;
  - `res_valid_o = 0`, `res_result_o = 0`, `res_branch_o = 0`, `res_idx_o = 0`, `res_trans_id_o = 0`;
  - `req_ready_o = 0`, and `alu_fu_data_o` follows its combinational rule.
- Reset mid-operation: in-flight FIFO entries are discarded and arbitration restarts at requester 0.
- Flush together with a push or pop: flush wins, and `cnt_q` is 0 in the next cycle.

## Test plan
- Single request:
  - Stimulus: requester 0 issues ADD with a=5, b=7, trans_id=3, consumer always ready.
  - Required: `req_ready_o = 01`. Next cycle `res_valid_o = 1`, `res_result_o = 12`, `res_idx_o = 0`, `res_trans_id_o = 3`. `rr_q` becomes 1.
- Fairness:
  - Stimulus: both requesters hold valid continuously for 6 cycles.
  - Required: grants alternate 0,1,0,1,0,1, and the `res_idx_o` sequence matches.
- Backpressure:
  - Stimulus: `res_ready_i = 0`; requester 1 issues SUB 10-3, then NE 4,4, then a third request.
  - Required: the first two requests are accepted; the third sees `req_ready_o = 00` while `cnt_q = 2`.
  - Then raise `res_ready_i`: pops return 7 followed by branch=0. The third request is accepted in the same cycle as the first pop.
- Wrap with `NR_REQ = 3`:
  - Stimulus: only requester 2 is valid, then all three are valid.
  - Required: after the grant to requester 2, `rr_q` wraps to 0, and the next grant order is 0,1,2.
- Flush:
  - Stimulus: with 2 entries queued, assert `flush_i` while requester 0 is valid.
  - Required: no accept that cycle; the next cycle has `res_valid_o = 0` and `cnt_q = 0`.
- Asynchronous reset mid-stream:
  - Stimulus: pull `rst_ni` low between clock edges while `res_valid_o = 1`.
  - Required: `res_valid_o` and all `res_*` outputs go to 0 immediately, and `rr_q = 0` after release.
